fx2_fifo_emu: RTL and testbench
===============================

FX2_FIFO_EMU -- requirements
Module: fx2_fifo_emu

Interface
Parameters (one per line: name, default, meaning):
REQ-001 OUT_DEPTH, 16, EP6OUT FIFO depth in bytes; a power of two, at least 4.
REQ-002 IN_DEPTH, 1024, EP8IN FIFO depth in bytes; a power of two, at least PKT_SIZE.
REQ-003 PKT_SIZE, 512, EP8IN auto-commit packet size in bytes; a power of two.

Ports (one per line: name  direction  width  meaning):
REQ-004 fx2Clk_in  in  1  Single clock; all logic is rising-edge on this clock.
REQ-005 reset_in  in  1  Reset; asynchronous, active-low.
REQ-006 fx2FifoSel_in  in  1  Endpoint select: 0 = EP6OUT (emulator sources data), 1 = EP8IN (emulator sinks data).
REQ-007 fx2Data_io  inout  8  FX2 data bus.
REQ-008 fx2Read_in  in  1  Read strobe, active-low.
REQ-009 fx2GotData_out  out  1  High when EP6OUT is non-empty.
REQ-010 fx2Write_in  in  1  Write strobe, active-low.
REQ-011 fx2GotRoom_out  out  1  High when EP8IN is not full.
REQ-012 fx2PktEnd_in  in  1  Early commit strobe, active-low.
REQ-013 hostWrData_in / hostWrValid_in / hostWrReady_out  in/in/out  8/1/1  Host-side push into EP6OUT.
REQ-014 hostRdData_out / hostRdValid_out / hostRdReady_in  out/out/in  8/1/1  Host-side pop of committed EP8IN bytes.
REQ-015 pktCommit_out / pktLen_out  out/out  1/log2(PKT_SIZE)+1  One-cycle pulse and byte count for each committed packet.
REQ-016 err_out  out  2  Sticky errors: bit0 = EP6OUT underflow read, bit1 = EP8IN overflow write.

Function
REQ-017 EP6OUT data path:
- fx2Data_io SHALL be driven combinationally with the EP6OUT head byte whenever fx2FifoSel_in=0.
- fx2Data_io SHALL be high-Z whenever fx2FifoSel_in=1.
- Head byte value when EP6OUT is empty: 8'h00.
REQ-018 EP6OUT pop: occurs on an edge where fx2FifoSel_in=0, fx2Read_in=0 and fx2GotData_out=1; the next byte becomes visible after that edge (zero-wait, first-word-fall-through).
REQ-019 EP6OUT underflow: fx2FifoSel_in=0, fx2Read_in=0 and empty -> no pointer change; err_out[0] set.
REQ-020 EP6OUT push: occurs on hostWrValid_in & hostWrReady_out; hostWrReady_out = not full.
REQ-021 EP6OUT simultaneous push and pop: both happen and occupancy is unchanged, including when the FIFO is full.
REQ-022 EP8IN push: on an edge where fx2FifoSel_in=1 and fx2Write_in=0:
- If fx2GotRoom_out=1: fx2Data_io is pushed and the uncommitted count increments.
- Else: the byte is dropped and err_out[1] is set.
REQ-023 Auto-commit: on the edge where the uncommitted count reaches PKT_SIZE, the uncommitted bytes become committed; next cycle pktCommit_out=1 and pktLen_out=PKT_SIZE.
REQ-024 Early commit: on an edge where fx2FifoSel_in=1 and fx2PktEnd_in=0, all uncommitted bytes are committed; next cycle pktCommit_out=1 and pktLen_out = that count.
- A count of zero still pulses, with pktLen_out=0 (zero-length packet).
REQ-025 Write and PktEnd on the same edge: the byte is included, then committed. If the byte completes PKT_SIZE, exactly one commit occurs, with pktLen_out=PKT_SIZE.
REQ-026 Strobes with fx2FifoSel_in deselected are ignored: fx2Read_in when Sel=1; fx2Write_in or fx2PktEnd_in when Sel=0.
REQ-027 Host read path:
- hostRdValid_out = (committed count > 0).
- hostRdData_out = committed head byte (first-word-fall-through).
- A pop occurs on hostRdValid_out & hostRdReady_in.
- Uncommitted bytes are never visible to the host.
REQ-028 Pointers wrap modulo depth. Occupancy counters are one bit wider than the pointers, so full and empty are distinguishable.
REQ-029 fx2GotRoom_out = (total EP8IN occupancy < IN_DEPTH). Host pop and FX2 push on the same edge both happen.
REQ-030 Commit pulse timing: pktCommit_out is high for exactly one cycle per commit. Back-to-back commits on consecutive edges yield consecutive pulses.

Reset
REQ-031 Assertion of reset_in (low) SHALL immediately set:
- all pointers and counters to 0;
- err_out=0, pktCommit_out=0, pktLen_out=0;
- fx2GotData_out=0, hostRdValid_out=0.
REQ-032 While in reset and after release: fx2GotRoom_out=1 and hostWrReady_out=1; FIFO RAM contents are don't-care.
REQ-033 Reset mid-transfer discards all buffered and uncommitted bytes, with no commit pulse; operation resumes on the first edge after deassertion.

Verification
REQ-034 Host pushes 8'h81, 00, 00, 00, 03; Sel=0, Read=0 held for 5 edges -> bytes appear on fx2Data_io in order, fx2GotData_out=0 after the 5th edge, err_out=0.
REQ-035 Sel=1, write 3 bytes AA, BB, CC, then PktEnd=0 for one cycle -> pktCommit_out pulse with pktLen_out=3; host then reads AA, BB, CC; hostRdValid_out=0 before the commit.
REQ-036 Write 512 bytes 0..255 repeated with no PktEnd -> a single commit with pktLen_out=512 the cycle after the 512th write; PktEnd alone afterwards -> pktLen_out=0.
REQ-037 Fill EP8IN to 1024 bytes with the host not reading -> fx2GotRoom_out=0; a further write sets err_out[1]; one host pop -> fx2GotRoom_out=1 the next cycle.
REQ-038 Read=0 with EP6OUT empty -> err_out[0]=1 and no pointer movement; full EP6OUT with simultaneous host push and FX2 pop -> occupancy stays at 16.
REQ-039 reset_in pulsed low after 100 uncommitted writes -> no pktCommit_out; hostRdValid_out=0; a subsequent PktEnd yields pktLen_out=0.

Source files
------------

// File: rtl/fx2_fifo_emu_if.sv
// FX2 slave-FIFO control strobes and status flags between the FPGA-side master and the emulator.
// The 8-bit data bus stays a top-level inout so tristate resolution happens at the port.
interface fx2_fifo_emu_if;
    logic fx2FifoSel;
    logic fx2Read;
    logic fx2GotData;
    logic fx2Write;
    logic fx2GotRoom;
    logic fx2PktEnd;

    modport master (
        output fx2FifoSel, fx2Read, fx2Write, fx2PktEnd,
        input  fx2GotData, fx2GotRoom
    );
    modport slave (
        input  fx2FifoSel, fx2Read, fx2Write, fx2PktEnd,
        output fx2GotData, fx2GotRoom
    );
endinterface

// File: rtl/fx2_fifo_emu.sv
// Cypress FX2 slave-FIFO emulator: EP6OUT sources host bytes onto the FX2 bus, EP8IN sinks bus
// bytes into packets that become host-visible only once committed (auto at PKT_SIZE or PktEnd).
module fx2_fifo_emu #(
    parameter int unsigned OUT_DEPTH = 16,
    parameter int unsigned IN_DEPTH  = 1024,
    parameter int unsigned PKT_SIZE  = 512
) (
    input  logic                      fx2Clk_in,
    input  logic                      reset_in,
    fx2_fifo_emu_if.slave             fx2,
    inout  wire  [7:0]                fx2Data_io,
    input  logic [7:0]                hostWrData_in,
    input  logic                      hostWrValid_in,
    output logic                      hostWrReady_out,
    output logic [7:0]                hostRdData_out,
    output logic                      hostRdValid_out,
    input  logic                      hostRdReady_in,
    output logic                      pktCommit_out,
    output logic [$clog2(PKT_SIZE):0] pktLen_out,
    output logic [1:0]                err_out
);
    localparam int unsigned OutAw = $clog2(OUT_DEPTH);
    localparam int unsigned OutCw = OutAw + 1;
    localparam int unsigned InAw  = $clog2(IN_DEPTH);
    localparam int unsigned InCw  = InAw + 1;
    localparam int unsigned PktW  = $clog2(PKT_SIZE) + 1;

    // EP6OUT: host -> FX2
    logic [7:0]       outMem [OUT_DEPTH];
    logic [OutAw-1:0] outWrPtr_q, outRdPtr_q;
    logic [OutCw-1:0] outCount_q, outCount_d;
    logic             outPush, outPop, outUnder, outFull;

    assign fx2.fx2GotData = (outCount_q != '0);
    assign outFull        = (outCount_q == OutCw'(OUT_DEPTH));
    assign outPop         = ~fx2.fx2FifoSel & ~fx2.fx2Read & fx2.fx2GotData;
    assign outUnder       = ~fx2.fx2FifoSel & ~fx2.fx2Read & ~fx2.fx2GotData;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign hostWrReady_out = ~outFull | outPop;
    assign outPush         = hostWrValid_in & hostWrReady_out;
    assign outCount_d      = outCount_q + OutCw'(outPush) - OutCw'(outPop);

    assign fx2Data_io = fx2.fx2FifoSel ? 8'hzz
                                       : (fx2.fx2GotData ? outMem[outRdPtr_q] : 8'h00);

    always_ff @(posedge fx2Clk_in) begin
        if (outPush) outMem[outWrPtr_q] <= hostWrData_in;
    end

    // EP8IN: FX2 -> host
    logic [7:0]      inMem [IN_DEPTH];
    logic [InAw-1:0] inWrPtr_q, inRdPtr_q;
    logic [InCw-1:0] inTotal_q, inTotal_d, inCom_q, inCom_d;
    logic [PktW-1:0] unc_q, unc_d, uncInc;
    logic            inPush, inOver, hostPop, autoCommit, earlyCommit, commit;

    assign fx2.fx2GotRoom  = (inTotal_q < InCw'(IN_DEPTH));
    assign inPush          = fx2.fx2FifoSel & ~fx2.fx2Write & fx2.fx2GotRoom;
    assign inOver          = fx2.fx2FifoSel & ~fx2.fx2Write & ~fx2.fx2GotRoom;
    assign hostRdValid_out = (inCom_q != '0);
    assign hostRdData_out  = inMem[inRdPtr_q];
    assign hostPop         = hostRdValid_out & hostRdReady_in;

    // The byte written this edge counts toward the packet, so Write+PktEnd commits it too.
    assign uncInc      = unc_q + PktW'(inPush);
    assign autoCommit  = inPush & (uncInc == PktW'(PKT_SIZE));
    assign earlyCommit = fx2.fx2FifoSel & ~fx2.fx2PktEnd;
    assign commit      = autoCommit | earlyCommit;

    always_comb begin
        unc_d     = commit ? '0 : uncInc;
        inCom_d   = inCom_q - InCw'(hostPop);
        if (commit) inCom_d = inCom_d + InCw'(uncInc);
        inTotal_d = inTotal_q + InCw'(inPush) - InCw'(hostPop);
    end

    always_ff @(posedge fx2Clk_in) begin
        if (inPush) inMem[inWrPtr_q] <= fx2Data_io;
    end

    always_ff @(posedge fx2Clk_in or negedge reset_in) begin
        if (!reset_in) begin
            outWrPtr_q    <= '0;
            outRdPtr_q    <= '0;
            outCount_q    <= '0;
            inWrPtr_q     <= '0;
            inRdPtr_q     <= '0;
            inTotal_q     <= '0;
            inCom_q       <= '0;
            unc_q         <= '0;
            pktCommit_out <= 1'b0;
            pktLen_out    <= '0;
            err_out       <= 2'b00;
        end else begin
            if (outPush) outWrPtr_q <= outWrPtr_q + OutAw'(1);
            if (outPop)  outRdPtr_q <= outRdPtr_q + OutAw'(1);
            outCount_q    <= outCount_d;
            if (inPush)  inWrPtr_q  <= inWrPtr_q + InAw'(1);
            if (hostPop) inRdPtr_q  <= inRdPtr_q + InAw'(1);
            inTotal_q     <= inTotal_d;
            inCom_q       <= inCom_d;
            unc_q         <= unc_d;
            pktCommit_out <= commit;
            pktLen_out    <= commit ? uncInc : '0;
            err_out       <= err_out | {inOver, outUnder};
        end
    end
endmodule

// File: tb/tb_fx2_fifo_emu.sv
// Directed bench for fx2_fifo_emu: a vector table for the basic paths, then hand sequences for
// auto/early commit, EP8IN full, EP6OUT full with simultaneous push/pop, and mid-transfer reset.
module tb_fx2_fifo_emu;
    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] tbDrive;
    wire  [7:0] fx2Data;
    logic [7:0] hostWrData, hostRdData;
    logic       hostWrValid, hostWrReady, hostRdValid, hostRdReady, pktCommit;
    logic [9:0] pktLen;
    logic [1:0] err;
    int         checks = 0;
    int         errors = 0;

    fx2_fifo_emu_if fx2If ();

    fx2_fifo_emu dut (
        .fx2Clk_in      (clk),
        .reset_in       (rstN),
        .fx2            (fx2If.slave),
        .fx2Data_io     (fx2Data),
        .hostWrData_in  (hostWrData),
        .hostWrValid_in (hostWrValid),
        .hostWrReady_out(hostWrReady),
        .hostRdData_out (hostRdData),
        .hostRdValid_out(hostRdValid),
        .hostRdReady_in (hostRdReady),
        .pktCommit_out  (pktCommit),
        .pktLen_out     (pktLen),
        .err_out        (err)
    );

    assign fx2Data = fx2If.fx2FifoSel ? tbDrive : 8'hzz;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel, rd, wr, pe;
        logic [7:0] dat;
        logic       hwv;
        logic [7:0] hwd;
        logic       hrr;
        logic       eGotData, eGotRoom;
        logic [7:0] eBus;
        logic       eRdValid;
        logic [7:0] eRdData;
        logic       eCommit;
        logic [9:0] eLen;
        logic [1:0] eErr;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle(input logic sel);
        fx2If.fx2FifoSel = sel;
        fx2If.fx2Read    = 1'b1;
        fx2If.fx2Write   = 1'b1;
        fx2If.fx2PktEnd  = 1'b1;
        hostWrValid      = 1'b0;
        hostRdReady      = 1'b0;
    endtask

    task automatic doReset();
        setIdle(1'b0);
        rstN = 1'b0;
        #1;
        chk("rst err", err, 2'b00);
        chk("rst commit", pktCommit, 0);
        chk("rst rdValid", hostRdValid, 0);
        chk("rst gotData", fx2If.fx2GotData, 0);
        chk("rst gotRoom", fx2If.fx2GotRoom, 1);
        chk("rst wrReady", hostWrReady, 1);
        step();
        rstN = 1'b1;
    endtask

    initial begin
        tbDrive    = 8'h00;
        hostWrData = 8'h00;
        setIdle(1'b0);
        rstN = 1'b0;
        // sel rd wr pe dat hwv hwd hrr | gotData gotRoom bus rdValid rdData commit len err
        vecs[0]  = '{0,1,1,1,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[1]  = '{0,1,1,1,8'h00,1,8'h81,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[2]  = '{0,1,1,1,8'h00,1,8'h00,0, 1,1,8'h81,0,8'h00,0,10'd0,2'd0};
        vecs[3]  = '{0,1,1,1,8'h00,1,8'h00,0, 1,1,8'h81,0,8'h00,0,10'd0,2'd0};
        vecs[4]  = '{0,1,1,1,8'h00,1,8'h00,0, 1,1,8'h81,0,8'h00,0,10'd0,2'd0};
        vecs[5]  = '{0,1,1,1,8'h00,1,8'h03,0, 1,1,8'h81,0,8'h00,0,10'd0,2'd0};
        vecs[6]  = '{0,1,1,1,8'h00,0,8'h00,0, 1,1,8'h81,0,8'h00,0,10'd0,2'd0};
        vecs[7]  = '{0,0,1,1,8'h00,0,8'h00,0, 1,1,8'h81,0,8'h00,0,10'd0,2'd0};
        vecs[8]  = '{0,0,1,1,8'h00,0,8'h00,0, 1,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[9]  = '{0,0,1,1,8'h00,0,8'h00,0, 1,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[10] = '{0,0,1,1,8'h00,0,8'h00,0, 1,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[11] = '{0,0,1,1,8'h00,0,8'h00,0, 1,1,8'h03,0,8'h00,0,10'd0,2'd0};
        vecs[12] = '{0,1,1,1,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[13] = '{1,1,0,1,8'hAA,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[14] = '{1,1,0,1,8'hBB,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[15] = '{1,1,0,1,8'hCC,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[16] = '{1,1,1,0,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[17] = '{1,1,1,1,8'h00,0,8'h00,0, 0,1,8'h00,1,8'hAA,1,10'd3,2'd0};
        vecs[18] = '{1,1,1,1,8'h00,0,8'h00,1, 0,1,8'h00,1,8'hAA,0,10'd0,2'd0};
        vecs[19] = '{1,1,1,1,8'h00,0,8'h00,1, 0,1,8'h00,1,8'hBB,0,10'd0,2'd0};
        vecs[20] = '{1,1,1,1,8'h00,0,8'h00,1, 0,1,8'h00,1,8'hCC,0,10'd0,2'd0};
        vecs[21] = '{0,1,0,0,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[22] = '{1,0,1,1,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[23] = '{0,0,1,1,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd0};
        vecs[24] = '{0,1,1,1,8'h00,0,8'h00,0, 0,1,8'h00,0,8'h00,0,10'd0,2'd1};

        step();
        doReset();

        for (int k = 0; k < NV; k++) begin
            fx2If.fx2FifoSel = vecs[k].sel;
            fx2If.fx2Read    = vecs[k].rd;
            fx2If.fx2Write   = vecs[k].wr;
            fx2If.fx2PktEnd  = vecs[k].pe;
            tbDrive          = vecs[k].dat;
            hostWrValid      = vecs[k].hwv;
            hostWrData       = vecs[k].hwd;
            hostRdReady      = vecs[k].hrr;
            #1;
            chk($sformatf("v%0d gotData", k), fx2If.fx2GotData, vecs[k].eGotData);
            chk($sformatf("v%0d gotRoom", k), fx2If.fx2GotRoom, vecs[k].eGotRoom);
            if (!vecs[k].sel) chk($sformatf("v%0d bus", k), fx2Data, vecs[k].eBus);
            chk($sformatf("v%0d rdValid", k), hostRdValid, vecs[k].eRdValid);
            if (vecs[k].eRdValid) chk($sformatf("v%0d rdData", k), hostRdData, vecs[k].eRdData);
            chk($sformatf("v%0d commit", k), pktCommit, vecs[k].eCommit);
            if (vecs[k].eCommit) chk($sformatf("v%0d len", k), pktLen, vecs[k].eLen);
            chk($sformatf("v%0d err", k), err, vecs[k].eErr);
            step();
        end

        // Auto-commit at 512, then a zero-length PktEnd, then fill EP8IN to 1024.
        doReset();
        setIdle(1'b1);
        fx2If.fx2Write = 1'b0;
        for (int i = 0; i < 512; i++) begin
            tbDrive = 8'(i);
            if (i == 511) begin
                chk("auto rdValid before", hostRdValid, 0);
                chk("auto commit before", pktCommit, 0);
            end
            step();
        end
        fx2If.fx2Write = 1'b1;
        #1;
        chk("auto commit", pktCommit, 1);
        chk("auto len", pktLen, 512);
        chk("auto rdValid", hostRdValid, 1);
        chk("auto rdData", hostRdData, 8'h00);
        step();
        chk("auto single pulse", pktCommit, 0);
        fx2If.fx2PktEnd = 1'b0;
        step();
        fx2If.fx2PktEnd = 1'b1;
        #1;
        chk("zlp commit", pktCommit, 1);
        chk("zlp len", pktLen, 0);
        fx2If.fx2Write = 1'b0;
        for (int i = 0; i < 512; i++) begin
            tbDrive = 8'(i + 7);
            if (i == 511) chk("room before full", fx2If.fx2GotRoom, 1);
            step();
        end
        fx2If.fx2Write = 1'b1;
        #1;
        chk("full gotRoom", fx2If.fx2GotRoom, 0);
        chk("full commit len", pktLen, 512);
        fx2If.fx2Write = 1'b0;
        tbDrive = 8'hEE;
        step();
        fx2If.fx2Write = 1'b1;
        #1;
        chk("overflow err", err, 2'b10);
        chk("overflow gotRoom", fx2If.fx2GotRoom, 0);
        hostRdReady = 1'b1;
        #1;
        chk("pop0 data", hostRdData, 8'h00);
        step();
        hostRdReady = 1'b0;
        #1;
        chk("room after pop", fx2If.fx2GotRoom, 1);
        chk("pop1 data", hostRdData, 8'h01);
        hostRdReady = 1'b1;
        fx2If.fx2Write = 1'b0;
        tbDrive = 8'h5A;
        step();
        hostRdReady = 1'b0;
        fx2If.fx2Write = 1'b1;
        #1;
        chk("pop+push room", fx2If.fx2GotRoom, 1);
        chk("pop+push data", hostRdData, 8'h02);
        fx2If.fx2Write = 1'b0;
        step();
        fx2If.fx2Write = 1'b1;
        #1;
        chk("refill gotRoom", fx2If.fx2GotRoom, 0);

        // Write+PktEnd completing a packet, then back-to-back early commits.
        doReset();
        setIdle(1'b1);
        fx2If.fx2Write = 1'b0;
        for (int i = 0; i < 511; i++) begin
            tbDrive = 8'(i);
            step();
        end
        fx2If.fx2PktEnd = 1'b0;
        step();
        fx2If.fx2Write  = 1'b1;
        fx2If.fx2PktEnd = 1'b1;
        #1;
        chk("wr+pe commit", pktCommit, 1);
        chk("wr+pe len", pktLen, 512);
        step();
        chk("wr+pe single", pktCommit, 0);
        fx2If.fx2Write  = 1'b0;
        fx2If.fx2PktEnd = 1'b0;
        step();
        fx2If.fx2Write = 1'b1;
        #1;
        chk("b2b first", pktCommit, 1);
        chk("b2b first len", pktLen, 1);
        step();
        fx2If.fx2PktEnd = 1'b1;
        #1;
        chk("b2b second", pktCommit, 1);
        chk("b2b second len", pktLen, 0);
        step();
        chk("b2b end", pktCommit, 0);

        // EP6OUT full with simultaneous host push and FX2 pop.
        doReset();
        setIdle(1'b0);
        hostWrValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hostWrData = 8'(8'h10 + i);
            step();
        end
        hostWrValid = 1'b0;
        #1;
        chk("ep6 full ready", hostWrReady, 0);
        chk("ep6 full bus", fx2Data, 8'h10);
        hostWrValid = 1'b1;
        hostWrData  = 8'hF0;
        fx2If.fx2Read = 1'b0;
        #1;
        chk("ep6 full pop ready", hostWrReady, 1);
        step();
        hostWrValid   = 1'b0;
        fx2If.fx2Read = 1'b1;
        #1;
        chk("ep6 still full", hostWrReady, 0);
        chk("ep6 next bus", fx2Data, 8'h11);
        fx2If.fx2Read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ep6 drain %0d", i), fx2Data, (i < 15) ? 8'(8'h11 + i) : 8'hF0);
            step();
        end
        fx2If.fx2Read = 1'b1;
        #1;
        chk("ep6 drained", fx2If.fx2GotData, 0);
        chk("ep6 no err", err, 2'b00);

        // Reset mid-transfer drops uncommitted bytes without a pulse.
        doReset();
        setIdle(1'b1);
        fx2If.fx2Write = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tbDrive = 8'(i);
            step();
        end
        fx2If.fx2Write = 1'b1;
        #1;
        chk("mid rdValid", hostRdValid, 0);
        rstN = 1'b0;
        #1;
        chk("mid rst commit", pktCommit, 0);
        chk("mid rst len", pktLen, 0);
        chk("mid rst rdValid", hostRdValid, 0);
        chk("mid rst gotRoom", fx2If.fx2GotRoom, 1);
        step();
        chk("mid rst no pulse", pktCommit, 0);
        rstN = 1'b1;
        fx2If.fx2PktEnd = 1'b0;
        step();
        fx2If.fx2PktEnd = 1'b1;
        #1;
        chk("post rst commit", pktCommit, 1);
        chk("post rst len", pktLen, 0);
        chk("post rst rdValid", hostRdValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
